// File: rtl/decode_execute_register.sv
// ID/EX pipeline register with load-use stall and branch-flush hazard control.
// A flushed slot is an all-zero bubble with ValidE=0, so it never writes state.
module decode_execute_register (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] RegisterData1,
  input  logic [31:0] RegisterData2,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic [31:0] ImmExtD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        BranchD,
  input  logic        ALUSrcD,
  input  logic [1:0]  ResultSrcD,
  input  logic [2:0]  ALUControlD,
  input  logic        PCSrcE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic        ValidE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD
);

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic        valid;
  } ex_t;

  ex_t  ex_d;
  ex_t  ex_q;
  logic lw_stall;
  logic flush_e;

  // A taken redirect suppresses the stall so the new PC is never held.
  assign lw_stall = (ex_q.result_src == 2'b01) & ex_q.valid & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == Rs1D) | (ex_q.rd == Rs2D)) & ~PCSrcE;
  assign flush_e  = lw_stall | PCSrcE;

  assign StallF = lw_stall;
  assign StallD = lw_stall;
  assign FlushD = PCSrcE;

  always_comb begin
    ex_d = '0;
    if (!flush_e) begin
      ex_d.rd1         = RegisterData1;
      ex_d.rd2         = RegisterData2;
      ex_d.imm_ext     = ImmExtD;
      ex_d.pc          = PCD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
      ex_d.reg_write   = RegWriteD;
      ex_d.mem_write   = MemWriteD;
      ex_d.jump        = JumpD;
      ex_d.branch      = BranchD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.result_src  = ResultSrcD;
      ex_d.alu_control = ALUControlD;
      ex_d.valid       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ex_q <= '0;
    else      ex_q <= ex_d;
  end

  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm_ext;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alu_src;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_control;
  assign ValidE      = ex_q.valid;

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: directed hazard scenarios plus random traffic
// compared every cycle against an execute-slot model (instruction record or bubble).
module tb_decode_execute_register;

  typedef struct packed {
    logic [31:0] rd1, rd2, imm, pc, pcp4;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mw, j, b, as;
    logic [1:0]  rsrc;
    logic [2:0]  aluc;
  } instr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pcsrc = 1'b0;
  instr_t d_in = '0;

  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic        StallF, StallD, FlushD;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Model: the execute slot holds either nothing (bubble) or one decoded instruction.
  bit     m_has = 1'b0;
  instr_t m_slot = '0;

  decode_execute_register dut (
    .clk(clk), .rst(rst),
    .RegisterData1(d_in.rd1), .RegisterData2(d_in.rd2),
    .Rs1D(d_in.rs1), .Rs2D(d_in.rs2), .RdD(d_in.rd),
    .ImmExtD(d_in.imm), .PCD(d_in.pc), .PCPlus4D(d_in.pcp4),
    .RegWriteD(d_in.rw), .MemWriteD(d_in.mw), .JumpD(d_in.j), .BranchD(d_in.b),
    .ALUSrcD(d_in.as), .ResultSrcD(d_in.rsrc), .ALUControlD(d_in.aluc),
    .PCSrcE(pcsrc),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .ValidE(ValidE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Load-use hazard as seen from the model: a real load in execute, nonzero
  // destination, read by the decode instruction, and no redirect this cycle.
  function automatic bit model_lw(bit redirect);
    return m_has && (m_slot.rsrc == 2'b01) && (m_slot.rd != 5'd0) &&
           ((m_slot.rd == d_in.rs1) || (m_slot.rd == d_in.rs2)) && !redirect;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      m_has  = 1'b0;
      m_slot = '0;
    end else if (model_lw(pcsrc) || pcsrc) begin
      m_has  = 1'b0;
      m_slot = '0;
    end else begin
      m_has  = 1'b1;
      m_slot = d_in;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_RD1E", RD1E, m_slot.rd1);
      chk("m_RD2E", RD2E, m_slot.rd2);
      chk("m_ImmExtE", ImmExtE, m_slot.imm);
      chk("m_PCE", PCE, m_slot.pc);
      chk("m_PCPlus4E", PCPlus4E, m_slot.pcp4);
      chk("m_Rs1E", 32'(Rs1E), 32'(m_slot.rs1));
      chk("m_Rs2E", 32'(Rs2E), 32'(m_slot.rs2));
      chk("m_RdE", 32'(RdE), 32'(m_slot.rd));
      chk("m_ctrl", {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE},
          {m_slot.rw, m_slot.mw, m_slot.j, m_slot.b, m_slot.as, m_slot.rsrc, m_slot.aluc});
      chk("m_ValidE", 32'(ValidE), 32'(m_has));
      chk("m_StallF", 32'(StallF), 32'(model_lw(pcsrc)));
      chk("m_StallD", 32'(StallD), 32'(model_lw(pcsrc)));
      chk("m_FlushD", 32'(FlushD), 32'(pcsrc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic [1:0] rsrc, logic [31:0] rd1);
    instr_t t = '0;
    t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.rsrc = rsrc; t.rd1 = rd1;
    t.rw = 1'b1; t.pc = 32'h100; t.pcp4 = 32'h104;
    return t;
  endfunction

  initial begin
    rst = 1'b0;
    d_in = mk(5'd1, 5'd1, 5'd1, 2'b01, 32'hdead);
    step();
    chk_en = 1'b1;
    chk("rst_ValidE", 32'(ValidE), 32'd0);
    chk("rst_RD1E", RD1E, 32'd0);
    chk("rst_StallD", 32'(StallD), 32'd0);
    step();
    rst = 1'b1;

    // plain instruction passes with one-cycle latency
    d_in = mk(5'd1, 5'd2, 5'd3, 2'b00, 32'h5555);
    step();
    chk("plain_RD1E", RD1E, 32'h5555);
    chk("plain_RdE", 32'(RdE), 32'd3);
    chk("plain_RegWriteE", 32'(RegWriteE), 32'd1);
    chk("plain_ValidE", 32'(ValidE), 32'd1);

    // load-use on Rs2: one bubble, then the held instruction advances
    d_in = mk(5'd0, 5'd0, 5'd5, 2'b01, 32'h0);
    step();
    d_in = mk(5'd9, 5'd5, 5'd6, 2'b00, 32'h1234);
    #1;
    chk("lu_StallF", 32'(StallF), 32'd1);
    chk("lu_StallD", 32'(StallD), 32'd1);
    step();
    chk("lu_bubble_ValidE", 32'(ValidE), 32'd0);
    chk("lu_bubble_RegWriteE", 32'(RegWriteE), 32'd0);
    chk("lu_bubble_StallD", 32'(StallD), 32'd0);
    step();
    chk("lu_adv_RdE", 32'(RdE), 32'd6);
    chk("lu_adv_RD1E", RD1E, 32'h1234);
    chk("lu_adv_ValidE", 32'(ValidE), 32'd1);

    // load to x0 never stalls
    d_in = mk(5'd0, 5'd0, 5'd0, 2'b01, 32'h0);
    step();
    d_in = mk(5'd0, 5'd0, 5'd9, 2'b00, 32'h77);
    #1;
    chk("x0_StallF", 32'(StallF), 32'd0);
    step();
    chk("x0_RdE", 32'(RdE), 32'd9);
    chk("x0_ValidE", 32'(ValidE), 32'd1);

    // taken branch overrides a matching load
    d_in = mk(5'd0, 5'd0, 5'd4, 2'b01, 32'h0);
    step();
    d_in = mk(5'd4, 5'd4, 5'd10, 2'b00, 32'h88);
    pcsrc = 1'b1;
    #1;
    chk("br_FlushD", 32'(FlushD), 32'd1);
    chk("br_StallF", 32'(StallF), 32'd0);
    chk("br_StallD", 32'(StallD), 32'd0);
    step();
    pcsrc = 1'b0;
    chk("br_ValidE", 32'(ValidE), 32'd0);

    // reset in the middle of a hazard
    d_in = mk(5'd0, 5'd0, 5'd7, 2'b01, 32'h99);
    step();
    d_in = mk(5'd7, 5'd0, 5'd11, 2'b00, 32'h42);
    rst = 1'b0;
    #1;
    chk("mr_pre_StallD", 32'(StallD), 32'd1);
    step();
    chk("mr_RD1E", RD1E, 32'd0);
    chk("mr_RdE", 32'(RdE), 32'd0);
    chk("mr_ValidE", 32'(ValidE), 32'd0);
    chk("mr_StallD", 32'(StallD), 32'd0);
    rst = 1'b1;

    // back-to-back ALU dependency needs no stall
    d_in = mk(5'd0, 5'd0, 5'd2, 2'b00, 32'h1);
    step();
    chk("alu1_ValidE", 32'(ValidE), 32'd1);
    d_in = mk(5'd2, 5'd0, 5'd8, 2'b00, 32'h2);
    #1;
    chk("alu_StallF", 32'(StallF), 32'd0);
    step();
    chk("alu2_ValidE", 32'(ValidE), 32'd1);
    chk("alu2_RdE", 32'(RdE), 32'd8);

    // random traffic; decode instruction is held while the model reports a stall
    for (int i = 0; i < 3000; i++) begin
      instr_t t;
      bit hold;
      hold = model_lw(1'b0) && rst;
      pcsrc = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 39) != 0);
      if (!hold) begin
        t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
        t.pc = $urandom; t.pcp4 = t.pc + 32'd4;
        t.rs1 = 5'($urandom_range(0, 7));
        t.rs2 = 5'($urandom_range(0, 7));
        t.rd = 5'($urandom_range(0, 7));
        t.rw = 1'($urandom); t.mw = 1'($urandom); t.j = 1'($urandom);
        t.b = 1'($urandom); t.as = 1'($urandom);
        t.rsrc = 2'($urandom_range(0, 2));
        t.aluc = 3'($urandom);
        d_in = t;
      end
      step();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_execute_register.md
DECODE_EXECUTE_REGISTER -- requirements
Module: decode_execute_register

Interface
REQ-001 clk  in  1  pipeline clock; all state SHALL update on posedge clk.
REQ-002 rst  in  1  synchronous, active-low reset; sampled only on posedge clk.
REQ-003 RegisterData1, RegisterData2  in  32 each  register-file read data, RD1D and RD2D.
REQ-004 Rs1D, Rs2D, RdD  in  5 each  source and destination register indices of the decode instruction.
REQ-005 ImmExtD, PCD, PCPlus4D  in  32 each  extended immediate, PC, and PC+4 of the decode instruction.
REQ-006 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  decode control bits.
REQ-007 ResultSrcD  in  2  result select: 00 ALU, 01 load, 10 PC+4.
REQ-008 ALUControlD  in  3  ALU operation.
REQ-009 PCSrcE  in  1  taken branch or jump resolved in execute.
REQ-010 RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  32 each  registered copies of the decode values.
REQ-011 Rs1E, Rs2E, RdE  out  5 each  registered register indices.
REQ-012 RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each; ResultSrcE  out  2; ALUControlE  out  3; all registered control.
REQ-013 ValidE  out  1  execute slot holds a real instruction, not a bubble.
REQ-014 StallF, StallD, FlushD  out  1 each  combinational hazard controls for the fetch stage and the IF/ID register.

Function
REQ-015 lwStall SHALL equal (ResultSrcE==2'b01) & ValidE & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)) & ~PCSrcE.
REQ-016 StallF and StallD SHALL equal lwStall; FlushD SHALL equal PCSrcE.
REQ-017 FlushE SHALL be internal and equal lwStall | PCSrcE.
REQ-018 On posedge with FlushE=0, every E register SHALL load its D input and ValidE SHALL become 1 (latency: 1 cycle).
REQ-019 On posedge with FlushE=1, every E register SHALL become 0 and ValidE SHALL become 0, forming a bubble with RegWriteE=MemWriteE=BranchE=JumpE=0.
REQ-020 The block SHALL NOT stall itself; a load-use hazard SHALL insert exactly one bubble, and the instruction held in decode SHALL enter execute on the following cycle.
REQ-021 A load whose RdE is x0 SHALL NOT cause a stall.
REQ-022 A bubble (ValidE=0) SHALL NOT cause a stall, even when its fields match.
REQ-023 When PCSrcE=1, lwStall SHALL be 0, so the redirect PC is never held by StallF.
REQ-024 When a hazard exists on both Rs1D and Rs2D, the block SHALL insert a single bubble only.
REQ-025 Write-back-to-decode hazards SHALL be out of scope; the register file writes on the falling edge, and this block SHALL NOT provide a bypass path.
REQ-026 StallF, StallD and FlushD SHALL be pure combinational functions of the current E registers, Rs1D, Rs2D and PCSrcE, with no dependence on the D data inputs.

Reset
REQ-027 While rst=0 at posedge, every E output SHALL become 0 and ValidE SHALL become 0; reset SHALL take priority over flush and load.
REQ-028 During reset and in the first cycle after it, StallF, StallD and FlushD SHALL be 0 unless PCSrcE=1.
REQ-029 Reset asserted mid-hazard SHALL clear the hazard: the cycle after release, lwStall=0.

Verification
REQ-030 Plain load: D carries RD1=0x5555, Rd=3, RegWriteD=1, no hazard -> next cycle RD1E=0x5555, RdE=3, RegWriteE=1, ValidE=1.
REQ-031 Load-use: E holds a load with RdE=5 and ValidE=1, D has Rs2D=5 -> StallF=StallD=1; next cycle ValidE=0 and RegWriteE=0; the cycle after, the D instruction appears in E and the stall is 0.
REQ-032 Load to x0: E holds a load with RdE=0, D has Rs1D=0 -> StallF=0, and the D instruction advances normally.
REQ-033 Branch taken: PCSrcE=1 while E holds a load matching Rs1D -> FlushD=1, StallF=StallD=0; next cycle ValidE=0.
REQ-034 Mid-run reset: rst=0 for one cycle while E holds a valid load with RdE=7 and D has Rs1D=7 -> after the edge all E outputs are 0, ValidE=0 and StallD=0.
REQ-035 Back-to-back ALU operations: D presents Rd=2 then Rs1=2 with ResultSrcD=00 -> no stall, and ValidE stays 1 on both cycles.
